// File: rtl/dec2to4_pulser.sv
// Sequential 2-to-4 decoder: 2-entry code FIFO feeding a one-hot strobe of PULSE_LEN cycles.
// Optional macro DEC_PULSE_GAP_EN inserts one all-zero cycle after every strobe.
module dec2to4_pulser #(
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_onehot,
  output logic       out_valid,
  output logic       done,
  output logic       busy
);

`ifdef DEC_PULSE_GAP_EN
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PULSE} state_t;
`endif

  localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

  logic [1:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop;
  logic [1:0] head;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] onehot_n;

  // Ready comes from the registered count only, so no input-to-output path.
  assign in_ready  = (count != 2'd2);
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign out_valid = |out_onehot;
  assign done      = (state == PULSE) && (cnt == 8'd0);
  assign busy      = (state != IDLE) || (count != 2'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      out_onehot <= 4'b0000;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      out_onehot <= onehot_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    onehot_n = out_onehot;
    pop      = 1'b0;
    case (state)
      PULSE: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
`ifdef DEC_PULSE_GAP_EN
          state_n  = GAP;
          onehot_n = 4'b0000;
`else
          // Back-to-back reload keeps strobes contiguous.
          if (count != 2'd0) begin
            pop      = 1'b1;
            onehot_n = 4'b0001 << head;
            cnt_n    = CNT_LOAD;
          end else begin
            state_n  = IDLE;
            onehot_n = 4'b0000;
          end
`endif
        end
      end
      default: begin
        // IDLE, and GAP which behaves as IDLE on its single cycle.
        if (count != 2'd0) begin
          pop      = 1'b1;
          onehot_n = 4'b0001 << head;
          cnt_n    = CNT_LOAD;
          state_n  = PULSE;
        end else begin
          state_n  = IDLE;
          onehot_n = 4'b0000;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_dec2to4_pulser.sv
// Randomized bench for dec2to4_pulser: two instances (PULSE_LEN 4 and 1) against a
// schedule model built from acceptance edges and strobe start edges.
module tb_dec2to4_pulser;

`ifdef DEC_PULSE_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int P0 = 4;
  localparam int P1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_code;
  logic       in_valid;
  logic [1:0] in_ready;
  logic [3:0] out_onehot [2];
  logic [1:0] out_valid, done, busy;

  int checks = 0;
  int errors = 0;
  int c;

  // Per instance: acceptance edge, strobe start edge and code of each transfer.
  int acc  [2][$];
  int st   [2][$];
  int code [2][$];

  always #5 clk = ~clk;

  dec2to4_pulser #(.PULSE_LEN(P0)) u_dut0 (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_onehot(out_onehot[0]), .out_valid(out_valid[0]),
    .done(done[0]), .busy(busy[0]));

  dec2to4_pulser #(.PULSE_LEN(P1)) u_dut1 (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_onehot(out_onehot[1]), .out_valid(out_valid[1]),
    .done(done[1]), .busy(busy[1]));

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %0h exp %0h", tag, d, c, obs, exp);
    end
  endtask

  function automatic int plen(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  // Codes in the FIFO during cycle cy: accepted by edge cy minus popped by edge cy.
  function automatic int mcount(input int d, input int cy);
    int n = 0;
    for (int i = 0; i < acc[d].size(); i++) begin
      if (acc[d][i] <= cy) n++;
      if (st[d][i]  <= cy) n--;
    end
    return n;
  endfunction

  function automatic logic [3:0] m_onehot(input int d, input int cy);
    logic [3:0] r = 4'b0000;
    for (int i = 0; i < st[d].size(); i++)
      if (cy >= st[d][i] && cy < st[d][i] + plen(d)) r = 4'(1 << code[d][i]);
    return r;
  endfunction

  function automatic logic m_done(input int d, input int cy);
    logic r = 1'b0;
    for (int i = 0; i < st[d].size(); i++)
      if (cy == st[d][i] + plen(d) - 1) r = 1'b1;
    return r;
  endfunction

  function automatic logic m_busy(input int d, input int cy);
    logic r = (mcount(d, cy) > 0);
    for (int i = 0; i < st[d].size(); i++)
      if (cy >= st[d][i] && cy < st[d][i] + plen(d) + G) r = 1'b1;
    return r;
  endfunction

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] oh;
      oh = m_onehot(d, c);
      chk("onehot", d, {4'h0, out_onehot[d]}, {4'h0, oh});
      chk("out_valid", d, {7'h0, out_valid[d]}, {7'h0, (oh != 4'b0000)});
      chk("done", d, {7'h0, done[d]}, {7'h0, m_done(d, c)});
      chk("busy", d, {7'h0, busy[d]}, {7'h0, m_busy(d, c)});
      chk("in_ready", d, {7'h0, in_ready[d]}, {7'h0, (mcount(d, c) < 2)});
    end
  endtask

  // Drive the inputs for edge c+1 and record which instance accepts them.
  task automatic drive(input int pct);
    logic       v;
    logic [1:0] cd;
    v  = ($urandom_range(0, 99) < pct);
    cd = 2'($urandom_range(0, 3));
    in_valid = v;
    in_code  = cd;
    for (int d = 0; d < 2; d++) begin
      if (v && mcount(d, c) < 2) begin
        int s;
        s = c + 2;
        if (st[d].size() > 0 && st[d][$] + plen(d) + G > s) s = st[d][$] + plen(d) + G;
        acc[d].push_back(c + 1);
        st[d].push_back(s);
        code[d].push_back(int'(cd));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_onehot"}, d, {4'h0, out_onehot[d]}, 8'h00);
      chk({tag, "_valid"}, d, {7'h0, out_valid[d]}, 8'h00);
      chk({tag, "_done"}, d, {7'h0, done[d]}, 8'h00);
      chk({tag, "_busy"}, d, {7'h0, busy[d]}, 8'h00);
      chk({tag, "_ready"}, d, {7'h0, in_ready[d]}, 8'h01);
    end
  endtask

  // Asserts reset mid-cycle, so queued codes and any live strobe are dropped.
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      acc[d].delete();
      st[d].delete();
      code[d].delete();
    end
    c = 0;
  endtask

  initial begin
    int pcts [4];
    pcts = '{100, 30, 85, 60};
    c        = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 2'd0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 120; k++) begin
        check_cycle();
        drive(pcts[r]);
        @(negedge clk);
        c++;
      end
      do_reset();
    end
    for (int k = 0; k < 4; k++) begin
      check_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      c++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
